// File: rtl/exclusive_min_n.sv
// exclusive_min_n
// N-channel earliest-edge detector for pulse-width-coded temporal networks.
// A free-running gamma counter frames time. Within each gamma the first
// rising edge among the inputs wins. The winner produces a pulse of
// PULSE_WIDTH cycles on q and latches its index and arrival time.
// A simultaneous multi-channel first edge either suppresses the output
// (EXCLUSIVE=1) or is resolved in favour of the lowest index (EXCLUSIVE=0).
// Every output is a plain register, so there is no combinational path from
// a to any output.
module exclusive_min_n #(
  parameter int N                 = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int EXCLUSIVE         = 1,
  localparam int ID_W   = (N > 1) ? $clog2(N) : 1,
  localparam int TIME_W = $clog2(GAMMA_CYCLE_WIDTH),
  localparam int PC_W   = $clog2(PULSE_WIDTH + 1)
) (
  input  logic              aclk,
  input  logic              grst,
  input  logic [N-1:0]      a,
  output logic              q,
  output logic [ID_W-1:0]   win_id,
  output logic              win_valid,
  output logic [TIME_W-1:0] win_time,
  output logic              tie,
  output logic              gamma_start
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_DONE,
    S_BLOCK
  } state_t;

  localparam logic [TIME_W-1:0] GC_LAST   = TIME_W'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [PC_W-1:0]   PCNT_LAST = PC_W'(PULSE_WIDTH - 1);

  state_t              r_state;
  state_t              w_nextState;

  logic [TIME_W-1:0]   r_gcnt;
  logic                r_run;
  logic                r_gstart;
  logic [N-1:0]        r_aq;
  logic [PC_W-1:0]     r_pcnt;
  logic                r_q;
  logic                r_winValid;
  logic [ID_W-1:0]     r_winId;
  logic [TIME_W-1:0]   r_winTime;
  logic                r_tie;

  logic [N-1:0]        w_rise;
  logic                w_multi;
  logic [ID_W-1:0]     w_lowId;
  logic                w_wrap;
  logic [TIME_W-1:0]   w_gcntNext;
  logic [PC_W-1:0]     w_pcntNext;
  logic                w_qNext;
  logic                w_validNext;
  logic [ID_W-1:0]     w_idNext;
  logic [TIME_W-1:0]   w_timeNext;
  logic                w_tieNext;

  // Rising edges seen at the coming clock edge and the lowest such channel.
  // rise & (rise-1) is non-zero exactly when two or more bits are set.
  always_comb begin
    w_rise  = a & ~r_aq;
    w_multi = |(w_rise & (w_rise - N'(1)));
    w_lowId = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rise[i]) begin
        w_lowId = ID_W'(i);
      end
    end
  end

  // Gamma counter sequencing. The first edge after reset only arms the
  // block, so gcnt reads 0 for a whole cycle before counting starts and the
  // first gamma is a full one with gamma_start flagged.
  always_comb begin
    w_wrap     = r_run && (r_gcnt == GC_LAST);
    w_gcntNext = '0;
    if (r_run && !w_wrap) begin
      w_gcntNext = r_gcnt + TIME_W'(1);
    end
  end

  // Gamma counter, start flag and input history registers.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      r_gcnt   <= '0;
      r_run    <= 1'b0;
      r_gstart <= 1'b0;
      r_aq     <= '0;
    end else begin
      r_gcnt   <= w_gcntNext;
      r_run    <= 1'b1;
      r_gstart <= (w_gcntNext == '0);
      r_aq     <= a;
    end
  end

  // Next-state and next-output logic. The wrap edge overrides every state
  // and throws away any edges sampled on it.
  always_comb begin
    w_nextState = r_state;
    w_pcntNext  = r_pcnt;
    w_qNext     = r_q;
    w_validNext = r_winValid;
    w_idNext    = r_winId;
    w_timeNext  = r_winTime;
    w_tieNext   = 1'b0;
    if (!r_run || w_wrap) begin
      w_nextState = S_IDLE;
      w_pcntNext  = '0;
      w_qNext     = 1'b0;
      w_validNext = 1'b0;
      w_idNext    = '0;
      w_timeNext  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise != '0) begin
            if (w_multi && (EXCLUSIVE != 0)) begin
              w_nextState = S_BLOCK;
              w_tieNext   = 1'b1;
            end else begin
              w_nextState = S_FIRE;
              w_pcntNext  = '0;
              w_qNext     = 1'b1;
              w_validNext = 1'b1;
              w_idNext    = w_lowId;
              w_timeNext  = r_gcnt;
            end
          end
        end
        S_FIRE: begin
          if (r_pcnt == PCNT_LAST) begin
            w_nextState = S_DONE;
            w_qNext     = 1'b0;
          end else begin
            w_pcntNext = r_pcnt + PC_W'(1);
          end
        end
        S_DONE, S_BLOCK: begin
          w_nextState = r_state;
        end
        default: begin
          w_nextState = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      r_state    <= S_IDLE;
      r_pcnt     <= '0;
      r_q        <= 1'b0;
      r_winValid <= 1'b0;
      r_winId    <= '0;
      r_winTime  <= '0;
      r_tie      <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_pcnt     <= w_pcntNext;
      r_q        <= w_qNext;
      r_winValid <= w_validNext;
      r_winId    <= w_idNext;
      r_winTime  <= w_timeNext;
      r_tie      <= w_tieNext;
    end
  end

  assign q           = r_q;
  assign win_id      = r_winId;
  assign win_valid   = r_winValid;
  assign win_time    = r_winTime;
  assign tie         = r_tie;
  assign gamma_start = r_gstart;

endmodule
